// File: rtl/owm_pkg.sv
// Shared encodings and default slot timing for the 1-wire slot controller.
package owm_pkg;

  typedef enum logic [1:0] {
    CMD_WRITE0 = 2'b00,
    CMD_WRITE1 = 2'b01,
    CMD_RESET  = 2'b10,
    CMD_RSVD   = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_REL  = 2'd2,
    ST_REC  = 2'd3
  } state_e;

  localparam int DEF_CW     = 10;
  localparam int DEF_T_RSTL = 480;
  localparam int DEF_T_PDS  = 70;
  localparam int DEF_T_RSTR = 410;
  localparam int DEF_T_LOW1 = 6;
  localparam int DEF_T_SMP  = 9;
  localparam int DEF_T_REC1 = 55;
  localparam int DEF_T_LOW0 = 60;
  localparam int DEF_T_REC0 = 10;

  // The reserved encoding behaves exactly like write1/read.
  function automatic cmd_e norm_cmd(input logic [1:0] raw);
    return (raw == 2'b11) ? CMD_WRITE1 : cmd_e'(raw);
  endfunction

  function automatic bit phase_ok(input int n, input int cw);
    return (n > 0) && (longint'(n) < (longint'(1) << cw));
  endfunction

endpackage

// File: rtl/owm_slot_ctrl_if.sv
// Command/response handshake and 1-wire line signals of the slot controller.
// Handshake: a command transfers on a clk where req_valid and req_ready are both high;
// rsp_valid is a one-clk pulse that needs no acknowledge.
interface owm_slot_ctrl_if;
  import owm_pkg::*;

  logic       req_valid;
  logic [1:0] req_cmd;
  logic       req_ready;
  logic       owr_i;
  logic       owr_e;
  logic       rsp_valid;
  logic       rsp_data;
  logic       busy;
  state_e     dbg_state;

  modport slave (
    input  req_valid, req_cmd, owr_i,
    output req_ready, owr_e, rsp_valid, rsp_data, busy, dbg_state
  );

  modport master (
    output req_valid, req_cmd, owr_i,
    input  req_ready, owr_e, rsp_valid, rsp_data, busy, dbg_state
  );
endinterface

// File: rtl/owm_timer.sv
// Phase timer: CW-bit down-counter with synchronous load, tick enable and zero flag.
module owm_timer #(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          tick_i,
  output logic          zero_o
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Load wins over tick so a tick on the loading cycle is not counted.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/owm_slot_ctrl.sv
// 1-wire slot sequencer: runs bus-reset, write0 and write1/read slots as
// LOW -> REL -> REC phases timed in ticks, and returns one result bit per slot.
module owm_slot_ctrl
  import owm_pkg::*;
#(
  parameter int CW     = DEF_CW,
  parameter int T_RSTL = DEF_T_RSTL,
  parameter int T_PDS  = DEF_T_PDS,
  parameter int T_RSTR = DEF_T_RSTR,
  parameter int T_LOW1 = DEF_T_LOW1,
  parameter int T_SMP  = DEF_T_SMP,
  parameter int T_REC1 = DEF_T_REC1,
  parameter int T_LOW0 = DEF_T_LOW0,
  parameter int T_REC0 = DEF_T_REC0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  abort,
  owm_slot_ctrl_if.slave        bus
);

  if (!(phase_ok(T_RSTL, CW) && phase_ok(T_PDS, CW)  && phase_ok(T_RSTR, CW) &&
        phase_ok(T_LOW1, CW) && phase_ok(T_SMP, CW)  && phase_ok(T_REC1, CW) &&
        phase_ok(T_LOW0, CW) && phase_ok(T_REC0, CW))) begin : g_bad_param
    $error("owm_slot_ctrl: a phase length is zero or does not fit in CW bits");
  end

  // Timer load values are N-1 so a phase ends on its N-th tick.
  localparam logic [CW-1:0] LD_RSTL = CW'(T_RSTL - 1);
  localparam logic [CW-1:0] LD_PDS  = CW'(T_PDS  - 1);
  localparam logic [CW-1:0] LD_RSTR = CW'(T_RSTR - 1);
  localparam logic [CW-1:0] LD_LOW1 = CW'(T_LOW1 - 1);
  localparam logic [CW-1:0] LD_SMP  = CW'(T_SMP  - 1);
  localparam logic [CW-1:0] LD_REC1 = CW'(T_REC1 - 1);
  localparam logic [CW-1:0] LD_LOW0 = CW'(T_LOW0 - 1);
  localparam logic [CW-1:0] LD_REC0 = CW'(T_REC0 - 1);

  state_e        state_q, state_d;
  cmd_e          cmd_q, cmd_d, cmd_in;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_data_q, rsp_data_d;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_zero;
  logic          phase_end;

  owm_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tick_i     (tick),
    .zero_o     (tmr_zero)
  );

  assign cmd_in    = norm_cmd(bus.req_cmd);
  assign phase_end = tick && tmr_zero;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          cmd_d    = cmd_in;
          state_d  = ST_LOW;
          tmr_load = 1'b1;
          case (cmd_in)
            CMD_RESET:  tmr_val = LD_RSTL;
            CMD_WRITE0: tmr_val = LD_LOW0;
            default:    tmr_val = LD_LOW1;
          endcase
        end
      end
      ST_LOW: begin
        if (phase_end) begin
          tmr_load = 1'b1;
          if (cmd_q == CMD_WRITE0) begin
            state_d    = ST_REC;
            tmr_val    = LD_REC0;
            rsp_data_d = 1'b0;
          end else begin
            state_d = ST_REL;
            tmr_val = (cmd_q == CMD_RESET) ? LD_PDS : LD_SMP;
          end
        end
      end
      ST_REL: begin
        if (phase_end) begin
          state_d    = ST_REC;
          tmr_load   = 1'b1;
          tmr_val    = (cmd_q == CMD_RESET) ? LD_RSTR : LD_REC1;
          // Presence is signalled by the slave holding the line low.
          rsp_data_d = (cmd_q == CMD_RESET) ? !bus.owr_i : bus.owr_i;
        end
      end
      ST_REC: begin
        if (phase_end) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides any phase completion in the same cycle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      tmr_load    = 1'b1;
      tmr_val     = '0;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_WRITE0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.owr_e     = (state_q == ST_LOW);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_owm_slot_ctrl.sv
// Directed bench for owm_slot_ctrl: slot timing, sampled results, abort and reset.
module tb_owm_slot_ctrl;
  import owm_pkg::*;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic tick  = 1'b1;
  logic abort = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int tick_div = 1;
  int div_cnt  = 0;

  owm_slot_ctrl_if bus ();

  owm_slot_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .abort (abort),
    .bus   (bus)
  );

  // Clock and timebase
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    div_cnt = (div_cnt + 1) % tick_div;
    tick    = (div_cnt == 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issues one command and follows it to its response. The slave model pulls owr_i
  // low on ticks lo..hi (tick 1 = first LOW tick). abort_tk / rst_tk cancel the slot
  // on that tick; the line state and ready are then checked one clk later.
  task automatic do_slot(input logic [1:0] cmd, input int lo, input int hi,
                         input int abort_tk, input int rst_tk,
                         output int n_low, output int n_cyc, output bit got, output bit rdata);
    int tk       = 0;
    bit fired    = 0;
    bit pending  = 0;
    bit post     = 0;
    int post_cnt = 0;
    int guard    = 0;
    n_low = 0;
    n_cyc = 0;
    got   = 0;
    rdata = 0;
    while (!tick && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    bus.req_cmd   = cmd;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check_val("accept_busy", bus.busy, 1);
        bus.req_valid = 1'b0;
      end
      if (bus.rsp_valid) begin
        got   = 1;
        rdata = bus.rsp_data;
        break;
      end
      if (bus.busy && tick) tk++;
      if (bus.owr_e) n_low++;
      if (bus.busy) n_cyc++;
      bus.owr_i = !(bus.owr_e || (tk >= lo && tk <= hi));
      if (pending) begin
        check_val("stop_owr_e", bus.owr_e, 0);
        check_val("stop_ready", bus.req_ready, 1);
        abort   = 1'b0;
        rst     = 1'b0;
        pending = 0;
        post    = 1;
      end else if (!fired && bus.busy && tick &&
                   ((abort_tk != 0 && tk == abort_tk) || (rst_tk != 0 && tk == rst_tk))) begin
        if (abort_tk != 0) abort = 1'b1;
        else rst = 1'b1;
        fired   = 1;
        pending = 1;
      end
      if (post) begin
        post_cnt++;
        if (post_cnt > 20) break;
      end
    end
    bus.owr_i = 1'b1;
  endtask

  int n_low, n_cyc;
  bit got, rdata;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_cmd   = 2'b00;
    bus.owr_i     = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_ready", bus.req_ready, 1);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_owr_e", bus.owr_e, 0);
    check_val("rst_rsp_valid", bus.rsp_valid, 0);
    check_val("rst_rsp_data", bus.rsp_data, 0);
    check_val("rst_state", bus.dbg_state, ST_IDLE);

    // Bus reset, slave presence pulse over ticks 481..550
    do_slot(2'b10, 481, 550, 0, 0, n_low, n_cyc, got, rdata);
    check_val("busrst_low", n_low, 480);
    check_val("busrst_busy", n_cyc, 960);
    check_val("busrst_rsp", got, 1);
    check_val("busrst_presence", rdata, 1);
    @(negedge clk);
    check_val("busrst_pulse_once", bus.rsp_valid, 0);
    check_val("busrst_hold", bus.rsp_data, 1);

    // Write1, line left high
    do_slot(2'b01, 1, 0, 0, 0, n_low, n_cyc, got, rdata);
    check_val("w1_low", n_low, 6);
    check_val("w1_busy", n_cyc, 70);
    check_val("w1_rsp", got, 1);
    check_val("w1_data", rdata, 1);

    // Write0 then a read issued on the write0 rsp_valid cycle
    @(negedge clk);
    do_slot(2'b00, 1, 0, 0, 0, n_low, n_cyc, got, rdata);
    check_val("w0_low", n_low, 60);
    check_val("w0_busy", n_cyc, 70);
    check_val("w0_rsp", got, 1);
    check_val("w0_data", rdata, 0);
    do_slot(2'b01, 1, 30, 0, 0, n_low, n_cyc, got, rdata);
    check_val("rd0_low", n_low, 6);
    check_val("rd0_busy", n_cyc, 70);
    check_val("rd0_rsp", got, 1);
    check_val("rd0_data", rdata, 0);

    // Reserved command acts as read; slave held through the sample tick, then released just before it
    @(negedge clk);
    do_slot(2'b11, 1, 15, 0, 0, n_low, n_cyc, got, rdata);
    check_val("rsvd_hold15_data", rdata, 0);
    check_val("rsvd_hold15_busy", n_cyc, 70);
    @(negedge clk);
    do_slot(2'b11, 1, 14, 0, 0, n_low, n_cyc, got, rdata);
    check_val("rsvd_hold14_low", n_low, 6);
    check_val("rsvd_hold14_data", rdata, 1);

    // Abort at tick 100 of a bus reset
    @(negedge clk);
    do_slot(2'b10, 481, 550, 100, 0, n_low, n_cyc, got, rdata);
    check_val("abort_no_rsp", got, 0);
    check_val("abort_low", n_low, 100);
    check_val("abort_data_hold", bus.rsp_data, 1);
    check_val("abort_state", bus.dbg_state, ST_IDLE);

    // Abort while idle
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("idle_abort_ready", bus.req_ready, 1);
    check_val("idle_abort_rsp", bus.rsp_valid, 0);

    // Tick every 4th clk
    tick_div = 4;
    @(negedge clk);
    do_slot(2'b00, 1, 0, 0, 0, n_low, n_cyc, got, rdata);
    check_val("div4_w0_low", n_low, 240);
    check_val("div4_w0_busy", n_cyc, 280);
    check_val("div4_w0_data", rdata, 0);
    @(negedge clk);
    do_slot(2'b01, 1, 0, 0, 0, n_low, n_cyc, got, rdata);
    check_val("div4_w1_low", n_low, 24);
    check_val("div4_w1_busy", n_cyc, 280);
    check_val("div4_w1_data", rdata, 1);

    // Synchronous reset during LOW of a write0
    @(negedge clk);
    do_slot(2'b00, 1, 0, 0, 3, n_low, n_cyc, got, rdata);
    check_val("midrst_no_rsp", got, 0);
    check_val("midrst_low", n_low, 12);
    check_val("midrst_data_clr", bus.rsp_data, 0);
    check_val("midrst_busy", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/owm_slot_ctrl.md
OWM_SLOT_CTRL -- requirements
Module: owm_slot_ctrl

Interface
REQ-001 SHALL have parameter CW, default 10: timer bit width.
REQ-002 SHALL have parameter T_RSTL, default 480: reset low phase, in ticks.
REQ-003 SHALL have parameter T_PDS, default 70: reset release-to-sample phase, in ticks.
REQ-004 SHALL have parameter T_RSTR, default 410: reset recovery phase, in ticks.
REQ-005 SHALL have parameter T_LOW1, default 6: write1/read low phase, in ticks.
REQ-006 SHALL have parameter T_SMP, default 9: write1/read release-to-sample phase, in ticks.
REQ-007 SHALL have parameter T_REC1, default 55: write1/read recovery phase, in ticks.
REQ-008 SHALL have parameter T_LOW0, default 60: write0 low phase, in ticks.
REQ-009 SHALL have parameter T_REC0, default 10: write0 recovery phase, in ticks.
REQ-010 SHALL have these ports:
  - clk  in  1  clock
  - rst  in  1  reset; synchronous, active-high
  - tick  in  1  timebase strobe, one clk wide
  - abort  in  1  synchronous cancel
  - req_valid  in  1  command offered
  - req_cmd  in  2  command: 00 write0, 01 write1/read, 10 bus reset, 11 reserved (treated as 01)
  - req_ready  out  1  command accepted when high with req_valid
  - owr_i  in  1  sampled 1-wire line
  - owr_e  out  1  line pull-low enable
  - rsp_valid  out  1  one-clk result pulse
  - rsp_data  out  1  sampled bit, or presence (1 = slave present)
  - busy  out  1  slot in progress

Function
REQ-011 SHALL implement states IDLE, LOW, REL, REC; req_ready = (state==IDLE); busy = !req_ready.
REQ-012 SHALL accept a command on a clk where req_valid and req_ready are both high, then enter LOW on the next cycle.
REQ-013 SHALL drive owr_e=1 exactly while in LOW, and owr_e=0 in every other state.
REQ-014 SHALL, on entry to each phase of length N ticks, load the timer with N-1.
REQ-015 SHALL decrement the timer on each tick; the phase ends on the tick seen while the timer is 0, so every phase lasts exactly N ticks.
REQ-016 SHALL ignore a tick on the accept cycle.
REQ-017 SHALL sequence bus reset as LOW(T_RSTL) -> REL(T_PDS) -> REC(T_RSTR); at the end of REL, rsp_data <= !owr_i.
REQ-018 SHALL sequence write1/read as LOW(T_LOW1) -> REL(T_SMP) -> REC(T_REC1); at the end of REL, rsp_data <= owr_i.
REQ-019 SHALL sequence write0 as LOW(T_LOW0) -> REC(T_REC0), skipping REL; rsp_data <= 0.
REQ-020 SHALL, at the end of REC, return to IDLE with rsp_valid=1 for that single clk; req_ready is high in the same cycle.
REQ-021 SHALL, when abort is high, enter IDLE on the next clk with owr_e=0 and the timer cleared, and SHALL NOT emit rsp_valid.
REQ-022 SHALL give abort priority over phase completion in the same cycle; abort in IDLE has no effect.
REQ-023 SHALL hold rsp_data stable until the next sample.
REQ-024 SHALL treat phase parameters of 0, or values that do not fit in CW bits, as illegal; this is checked by an elaboration assertion.

Reset
REQ-025 SHALL, while rst=1 on a clk edge, set state=IDLE, timer=0, owr_e=0, rsp_valid=0, rsp_data=0, req_ready=1 (from the next cycle).
REQ-026 SHALL, on rst mid-slot, release the line on the next clk and emit no response.

Structure
REQ-027 SHALL place in package owm_pkg: command encodings, state encoding, and default timing constants.
REQ-028 SHALL instantiate one sub-module, owm_timer: a CW-bit down-counter with synchronous load, tick enable and zero flag.

Verification (tick every clk unless stated)
REQ-029 SHALL cover bus reset with owr_i=0 during ticks 481-550 -> owr_e high 480 ticks, rsp_data=1, rsp_valid 960 ticks after accept.
REQ-030 SHALL cover write1 with owr_i=1 -> owr_e high 6 ticks, rsp_data=1, rsp_valid after 70 ticks.
REQ-031 SHALL cover write0 -> owr_e high 60 ticks, rsp_data=0, rsp_valid after 70 ticks; back-to-back request accepted on the rsp_valid cycle.
REQ-032 SHALL cover read with slave holding owr_i=0 through tick 30 -> rsp_data=0.
REQ-033 SHALL cover abort at tick 100 of a bus reset -> owr_e=0 and req_ready=1 next clk, no rsp_valid.
REQ-034 SHALL cover tick every 4th clk, plus rst asserted mid-LOW -> phase durations scale x4, and rst releases the line within 1 clk.
